udma_mdio_master: RTL and testbench
===================================

UDMA_MDIO_MASTER -- requirements
Module: udma_mdio_master

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the MDC half-period divider.
REQ-002 SHALL have parameter PRE_LEN, default 32, preamble length in MDC bit periods (1..63).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port clk_div_i  input  DIV_W  MDC half-period minus one, in clk_i cycles; 0 treated as 1.
REQ-006 SHALL have port req_valid_i  input  1  request valid.
REQ-007 SHALL have port req_ready_o  output  1  request accepted when req_valid_i & req_ready_o.
REQ-008 SHALL have port req_c45_i  input  1  0 = Clause 22 frame, 1 = Clause 45 frame.
REQ-009 SHALL have port req_op_i  input  2  opcode field, sent verbatim.
REQ-010 SHALL have port req_pre_sup_i  input  1  1 = omit preamble.
REQ-011 SHALL have port req_phy_i  input  5  PHYAD/PRTAD.
REQ-012 SHALL have port req_reg_i  input  5  REGAD/DEVAD.
REQ-013 SHALL have port req_data_i  input  16  write data or C45 address.
REQ-014 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-015 SHALL have port rd_data_o  output  16  read data, valid with rsp_valid_o.
REQ-016 SHALL have port err_o  output  1  turnaround error, valid with rsp_valid_o.
REQ-017 SHALL have ports mdc_o output 1, mdo_o output 1, md_oen_o output 1 (1 = drive MDIO), mdi_i input 1.
REQ-018 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, PRE, HDR, TA, DATA, DONE.
REQ-020 req_ready_o SHALL be high only in IDLE; on acceptance, all req_* fields and clk_div_i are latched, and the state moves to PRE (or to HDR if req_pre_sup_i).
REQ-021 Bit period = 2*(D+1) clk_i cycles, D = latched divider; mdc_o low for the first D+1 cycles and high for the next D+1 cycles.
REQ-022 mdo_o SHALL change only in the first cycle of each bit period; mdi_i SHALL be sampled in the cycle mdc_o goes high.
REQ-023 PRE: PRE_LEN bits of 1, md_oen_o = 1.
REQ-024 HDR: 14 bits MSB first: ST (01 if C22, 00 if C45), req_op_i, req_phy_i, req_reg_i.
REQ-025 TA: 2 bits; a write-type op (op[1] = 0) drives 1,0; a read-type op (op[1] = 1) sets md_oen_o = 0 from TA bit 1 until DONE.
REQ-026 DATA: 16 bits MSB first; write-type drives req_data_i; read-type shifts mdi_i into rd_data_o, MSB first.
REQ-027 DONE: lasts 1 cycle after the final bit period; rsp_valid_o = 1, mdc_o = 0, md_oen_o = 0; then IDLE.
REQ-028 Frame length SHALL be (PRE_LEN or 0) + 32 bits; C22 default write with D = 1 takes 256 cycles from acceptance to DONE.
REQ-029 rd_data_o SHALL hold its value until the next read completes; for writes it is unchanged.
REQ-030 In IDLE: mdc_o = 0, md_oen_o = 0, mdo_o = 1.
REQ-031 req_valid_i asserted outside IDLE SHALL be ignored until IDLE; there is no queueing.
REQ-032 A change to clk_div_i mid-frame SHALL NOT affect the current frame.

Reset
REQ-033 While rst_i = 1 at a clk_i edge: state = IDLE, mdc_o = 0, mdo_o = 1, md_oen_o = 0, req_ready_o = 0, rsp_valid_o = 0, err_o = 0, rd_data_o = 0, busy_o = 0, counters = 0.
REQ-034 Reset mid-frame SHALL abort the frame without a rsp_valid_o pulse; req_ready_o = 1 in the first cycle after rst_i deasserts.

Configuration
REQ-035 Macro UDMA_MDIO_TA_CHECK_EN defined: for read-type ops, mdi_i sampled in TA bit 2 is captured; err_o = 1 with rsp_valid_o if that value is 1, else 0.
REQ-036 Macro UDMA_MDIO_TA_CHECK_EN undefined: err_o is constant 0; TA sampling logic is absent.

Verification
REQ-037 D=1, C22, op 01, phy 5, reg 2, data 0xA5A5, no suppression -> mdo_o shows 32x1, 0101 00101 00010 10, then 0xA5A5 MSB first; rsp_valid_o at cycle 256; err_o = 0.
REQ-038 C22 read op 10, PHY model drives 0, then 0x1234 -> md_oen_o = 0 from TA bit 1; rd_data_o = 0x1234; err_o = 0.
REQ-039 Read with PHY driving 1 in TA bit 2, macro defined -> err_o = 1; macro undefined -> err_o = 0.
REQ-040 C45 address frame (op 00, data 0x0010), then C45 read op 11 returning 0xBEEF, pre_sup = 1 -> ST = 00, no preamble, 128 cycles per frame at D=1, rd_data_o = 0xBEEF.
REQ-041 rst_i pulsed at cycle 100 of a write -> outputs at reset values next cycle, no rsp_valid_o; a new request is accepted immediately after and completes normally.
REQ-042 clk_div_i = 0 vs 1 -> identical timing; clk_div_i changed mid-frame -> period unchanged until the next frame.

Source files
------------

// File: rtl/udma_mdio_master.sv
// ============================================================================
// Module      : udma_mdio_master
// Description : MDIO (Clause 22 / Clause 45) management frame master with a
//               programmable MDC divider. Optional turnaround check enabled by
//               defining UDMA_MDIO_TA_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udma_mdio_master #(
    parameter int DIV_W   = 8,
    parameter int PRE_LEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_c45_i,
    input  logic [1:0]       req_op_i,
    input  logic             req_pre_sup_i,
    input  logic [4:0]       req_phy_i,
    input  logic [4:0]       req_reg_i,
    input  logic [15:0]      req_data_i,
    output logic             rsp_valid_o,
    output logic [15:0]      rd_data_o,
    output logic             err_o,
    output logic             mdc_o,
    output logic             mdo_o,
    output logic             md_oen_o,
    input  logic             mdi_i,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [5:0] c_pre_last = 6'(PRE_LEN - 1);

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [5:0]       r_bit;
    logic [15:0]      r_sr;
    logic [15:0]      r_data;
    logic [15:0]      r_rx;
    logic             r_read;

    logic             w_active;
    logic             w_half_end;
    logic             w_bit_end;
    logic             w_sample;
    logic [13:0]      w_hdr;
    logic [DIV_W-1:0] w_div_eff;

    assign w_active   = (r_state == S_PRE) || (r_state == S_HDR) ||
                        (r_state == S_TA)  || (r_state == S_DATA);
    assign w_half_end = (r_cnt == r_div);
    assign w_bit_end  = w_active && mdc_o && w_half_end;
    // PHY data is taken at the end of the first MDC-high cycle
    assign w_sample   = w_active && mdc_o && (r_cnt == '0);
    assign w_hdr      = {1'b0, ~req_c45_i, req_op_i, req_phy_i, req_reg_i};
    assign w_div_eff  = (clk_div_i == '0) ? DIV_W'(1) : clk_div_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            mdc_o       <= 1'b0;
            mdo_o       <= 1'b1;
            md_oen_o    <= 1'b0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rd_data_o   <= 16'h0000;
            busy_o      <= 1'b0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_bit       <= 6'd0;
            r_sr        <= 16'h0000;
            r_data      <= 16'h0000;
            r_rx        <= 16'h0000;
            r_read      <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (w_active) begin
                if (w_half_end) begin
                    r_cnt <= '0;
                    mdc_o <= ~mdc_o;
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
                if (w_sample && (r_state == S_DATA)) begin
                    r_rx <= {r_rx[14:0], mdi_i};
                end
            end

            case (r_state)
                S_IDLE: begin
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    mdc_o       <= 1'b0;
                    md_oen_o    <= 1'b0;
                    mdo_o       <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        md_oen_o    <= 1'b1;
                        r_div       <= w_div_eff;
                        r_cnt       <= '0;
                        r_bit       <= 6'd0;
                        r_sr        <= {w_hdr, 2'b00};
                        r_data      <= req_data_i;
                        r_read      <= req_op_i[1];
                        if (req_pre_sup_i) begin
                            r_state <= S_HDR;
                            mdo_o   <= w_hdr[13];
                        end else begin
                            r_state <= S_PRE;
                            mdo_o   <= 1'b1;
                        end
                    end
                end
                S_PRE: begin
                    if (w_bit_end) begin
                        if (r_bit == c_pre_last) begin
                            r_state <= S_HDR;
                            r_bit   <= 6'd0;
                            mdo_o   <= r_sr[15];
                        end else begin
                            r_bit <= r_bit + 6'd1;
                        end
                    end
                end
                S_HDR: begin
                    if (w_bit_end) begin
                        if (r_bit == 6'd13) begin
                            r_state  <= S_TA;
                            r_bit    <= 6'd0;
                            mdo_o    <= 1'b1;
                            md_oen_o <= ~r_read;
                        end else begin
                            r_bit <= r_bit + 6'd1;
                            r_sr  <= {r_sr[14:0], 1'b0};
                            mdo_o <= r_sr[14];
                        end
                    end
                end
                S_TA: begin
                    if (w_bit_end) begin
                        if (r_bit == 6'd0) begin
                            r_bit <= 6'd1;
                            mdo_o <= r_read;
                        end else begin
                            r_state <= S_DATA;
                            r_bit   <= 6'd0;
                            r_sr    <= r_data;
                            mdo_o   <= r_read | r_data[15];
                        end
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == 6'd15) begin
                            r_state     <= S_DONE;
                            mdc_o       <= 1'b0;
                            md_oen_o    <= 1'b0;
                            mdo_o       <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            if (r_read) begin
                                rd_data_o <= r_rx;
                            end
                        end else begin
                            r_bit <= r_bit + 6'd1;
                            r_sr  <= {r_sr[14:0], 1'b0};
                            mdo_o <= r_read | r_sr[14];
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    r_cnt       <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UDMA_MDIO_TA_CHECK_EN
    logic r_ta_bad;
    logic r_err;

    // A PHY that answers must pull MDIO low in the second turnaround bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ta_bad <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == S_TA) && (r_bit == 6'd1) && w_sample) begin
                r_ta_bad <= mdi_i & r_read;
            end
            r_err <= (r_state == S_DATA) && w_bit_end && (r_bit == 6'd15) && r_ta_bad;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_udma_mdio_master.sv
// Directed, table-driven bench for udma_mdio_master with a small PHY model
// and corner sequences for reset and request handling.
`default_nettype none

module tb_udma_mdio_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  clk_div_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_c45_i;
    logic [1:0]  req_op_i;
    logic        req_pre_sup_i;
    logic [4:0]  req_phy_i;
    logic [4:0]  req_reg_i;
    logic [15:0] req_data_i;
    logic        rsp_valid_o;
    logic [15:0] rd_data_o;
    logic        err_o;
    logic        mdc_o;
    logic        mdo_o;
    logic        md_oen_o;
    logic        mdi_i;
    logic        busy_o;

    int n_pass  = 0;
    int n_total = 0;

`ifdef UDMA_MDIO_TA_CHECK_EN
    localparam logic c_ta_err = 1'b1;
`else
    localparam logic c_ta_err = 1'b0;
`endif

    udma_mdio_master #(.DIV_W(8), .PRE_LEN(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .clk_div_i    (clk_div_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_c45_i    (req_c45_i),
        .req_op_i     (req_op_i),
        .req_pre_sup_i(req_pre_sup_i),
        .req_phy_i    (req_phy_i),
        .req_reg_i    (req_reg_i),
        .req_data_i   (req_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rd_data_o    (rd_data_o),
        .err_o        (err_o),
        .mdc_o        (mdc_o),
        .mdo_o        (mdo_o),
        .md_oen_o     (md_oen_o),
        .mdi_i        (mdi_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        c45;
        logic [1:0]  op;
        logic        sup;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] data;
        logic [7:0]  div;
        logic [7:0]  div_mid;
        logic        hold;
        logic [15:0] phy_data;
        logic        ta2;
        int          cycles;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic c45, input logic [1:0] op, input logic sup,
                                input logic [4:0] phy, input logic [4:0] rg,
                                input logic [15:0] data, input logic [7:0] div,
                                input logic [7:0] div_mid, input logic hold,
                                input logic [15:0] phy_data, input logic ta2,
                                input int cycles, input logic [15:0] exp_rd,
                                input logic exp_err);
        vec_t v;
        v.c45 = c45; v.op = op; v.sup = sup; v.phy = phy; v.rg = rg; v.data = data;
        v.div = div; v.div_mid = div_mid; v.hold = hold; v.phy_data = phy_data;
        v.ta2 = ta2; v.cycles = cycles; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // PHY model: idle-high bus, TA bit 2 and 16 data bits on reads
    function automatic logic phy_bit(input vec_t v, input int idx);
        int pre;
        int j;
        pre = v.sup ? 0 : 32;
        if (!v.op[1]) return 1'b1;
        if (idx == pre + 15) return v.ta2;
        if (idx >= pre + 16 && idx <= pre + 31) begin
            j = 15 - (idx - pre - 16);
            return v.phy_data[j];
        end
        return 1'b1;
    endfunction

    function automatic logic [63:0] sh(input logic [63:0] x, input logic b);
        return {x[62:0], b};
    endfunction

    task automatic build(input vec_t v, output logic [63:0] d, output logic [63:0] m,
                         output logic [63:0] o, output int nb);
        logic [13:0] hdr;
        logic        rd;
        d = '0; m = '0; o = '0; nb = 0;
        rd = v.op[1];
        if (!v.sup) begin
            for (int i = 0; i < 32; i++) begin
                d = sh(d, 1'b1); m = sh(m, 1'b1); o = sh(o, 1'b1); nb++;
            end
        end
        hdr = {1'b0, ~v.c45, v.op, v.phy, v.rg};
        for (int i = 13; i >= 0; i--) begin
            d = sh(d, hdr[i]); m = sh(m, 1'b1); o = sh(o, 1'b1); nb++;
        end
        for (int i = 0; i < 2; i++) begin
            d = sh(d, !rd && (i == 0)); m = sh(m, !rd); o = sh(o, !rd); nb++;
        end
        for (int i = 15; i >= 0; i--) begin
            d = sh(d, !rd && v.data[i]); m = sh(m, !rd); o = sh(o, !rd); nb++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [63:0] exp_d, exp_m, exp_o, obs_d, obs_o;
        int          exp_nb, nbits, n, bidx, rdy_bad;
        logic        prev, done;
        build(v, exp_d, exp_m, exp_o, exp_nb);
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_ready", tag), 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1; req_c45_i = v.c45; req_op_i = v.op; req_pre_sup_i = v.sup;
        req_phy_i = v.phy; req_reg_i = v.rg; req_data_i = v.data; clk_div_i = v.div;
        bidx = 0;
        mdi_i = phy_bit(v, 0);
        @(negedge clk);
        if (v.hold) begin
            req_data_i = ~v.data;
            req_phy_i  = ~v.phy;
        end else begin
            req_valid_i = 1'b0;
        end
        clk_div_i = v.div_mid;
        n = 0; nbits = 0; rdy_bad = 0; prev = 1'b0; done = 1'b0;
        obs_d = '0; obs_o = '0;
        while (!done && n < 5000) begin
            if (rsp_valid_o) begin
                done = 1'b1;
            end else begin
                if (mdc_o && !prev) begin
                    obs_d = sh(obs_d, mdo_o);
                    obs_o = sh(obs_o, md_oen_o);
                    nbits++;
                end
                if (!mdc_o && prev) begin
                    bidx++;
                    mdi_i = phy_bit(v, bidx);
                end
                if (req_ready_o || !busy_o) rdy_bad++;
                prev = mdc_o;
                @(negedge clk);
                n++;
            end
        end
        req_valid_i = 1'b0;
        mdi_i = 1'b1;
        chk($sformatf("%s_done", tag), 64'(done), 64'd1);
        chk($sformatf("%s_cycles", tag), 64'(n), 64'(v.cycles));
        chk($sformatf("%s_nbits", tag), 64'(nbits), 64'(exp_nb));
        chk($sformatf("%s_mdo", tag), obs_d & exp_m, exp_d);
        chk($sformatf("%s_oen", tag), obs_o, exp_o);
        chk($sformatf("%s_rd_data", tag), 64'(rd_data_o), 64'(v.exp_rd));
        chk($sformatf("%s_err", tag), 64'(err_o), 64'(v.exp_err));
        chk($sformatf("%s_busy_ready", tag), 64'(rdy_bad), 64'd0);
        @(negedge clk);
        chk($sformatf("%s_pulse", tag), 64'(rsp_valid_o), 64'd0);
        chk($sformatf("%s_idle", tag),
            64'({req_ready_o, busy_o, mdc_o, md_oen_o, mdo_o}), 64'b10001);
    endtask

    vec_t vecs[10];

    initial begin
        logic rsp_seen;
        vecs[0] = mk(0, 2'b01, 0, 5'd5,  5'd2,  16'hA5A5, 8'd1, 8'd1, 0, 16'h0000, 0, 256, 16'h0000, 0);
        vecs[1] = mk(0, 2'b10, 0, 5'd1,  5'd3,  16'h0000, 8'd1, 8'd1, 0, 16'h1234, 0, 256, 16'h1234, 0);
        vecs[2] = mk(0, 2'b10, 0, 5'd1,  5'd3,  16'h0000, 8'd1, 8'd1, 0, 16'h5A5A, 1, 256, 16'h5A5A, c_ta_err);
        vecs[3] = mk(1, 2'b00, 1, 5'd2,  5'd1,  16'h0010, 8'd1, 8'd1, 0, 16'h0000, 0, 128, 16'h5A5A, 0);
        vecs[4] = mk(1, 2'b11, 1, 5'd2,  5'd1,  16'h0000, 8'd1, 8'd1, 0, 16'hBEEF, 0, 128, 16'hBEEF, 0);
        vecs[5] = mk(0, 2'b01, 1, 5'd7,  5'd4,  16'h1357, 8'd0, 8'd0, 0, 16'h0000, 0, 128, 16'hBEEF, 0);
        vecs[6] = mk(0, 2'b01, 1, 5'd7,  5'd4,  16'h2468, 8'd1, 8'd5, 0, 16'h0000, 0, 128, 16'hBEEF, 0);
        vecs[7] = mk(0, 2'b01, 1, 5'd7,  5'd4,  16'h9BDF, 8'd5, 8'd5, 0, 16'h0000, 0, 384, 16'hBEEF, 0);
        vecs[8] = mk(0, 2'b10, 0, 5'd31, 5'd31, 16'h0000, 8'd2, 8'd2, 0, 16'h8001, 0, 384, 16'h8001, 0);
        vecs[9] = mk(0, 2'b01, 1, 5'd3,  5'd9,  16'hC3C3, 8'd1, 8'd1, 1, 16'h0000, 0, 128, 16'h8001, 0);

        rst_i = 1'b1; clk_div_i = 8'd1; req_valid_i = 1'b0; req_c45_i = 1'b0;
        req_op_i = 2'b00; req_pre_sup_i = 1'b0; req_phy_i = '0; req_reg_i = '0;
        req_data_i = '0; mdi_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_lines",
            64'({mdc_o, mdo_o, md_oen_o, req_ready_o, rsp_valid_o, err_o, busy_o}), 64'b0100000);
        chk("reset_rd_data", 64'(rd_data_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready_o), 64'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort a write 100 cycles in, then prove the master recovers
        req_valid_i = 1'b1; req_c45_i = 1'b0; req_op_i = 2'b01; req_pre_sup_i = 1'b0;
        req_phy_i = 5'd5; req_reg_i = 5'd2; req_data_i = 16'hA5A5; clk_div_i = 8'd1;
        @(negedge clk);
        req_valid_i = 1'b0;
        rsp_seen = 1'b0;
        repeat (100) begin
            if (rsp_valid_o) rsp_seen = 1'b1;
            @(negedge clk);
        end
        chk("midrst_busy_before", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_lines",
            64'({mdc_o, mdo_o, md_oen_o, req_ready_o, rsp_valid_o, err_o, busy_o}), 64'b0100000);
        chk("midrst_rd_data", 64'(rd_data_o), 64'd0);
        chk("midrst_no_rsp", 64'(rsp_seen), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(req_ready_o), 64'd1);
        run_vec(vecs[0], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
